// File: rtl/belt_warn_ctrl.sv
// belt_warn_ctrl: timed seatbelt-warning controller.
// A violation (key present, occupant present, belt open) starts a grace delay.
// A pulsing chime follows for a bounded time. The warning light then stays on
// alone until the violation clears or the key is removed.
// Outputs are registered Moore-style: there is no combinational path from
// the inputs to W, C or State.
module belt_warn_ctrl #(
    parameter int TICK_DIV    = 1000,
    parameter int DELAY_TICKS = 3,
    parameter int CHIME_TICKS = 10,
    parameter int BLINK_HALF  = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       K,
    input  logic       P,
    input  logic       S,
    output logic       W,
    output logic       C,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SAFE  = 3'd1,
        WAIT  = 3'd2,
        CHIME = 3'd3,
        LIGHT = 3'd4
    } state_t;

    localparam int TICK_MAX = (DELAY_TICKS > CHIME_TICKS) ? DELAY_TICKS : CHIME_TICKS;
    localparam int PRE_W    = $clog2(TICK_DIV) + 1;
    localparam int TCNT_W   = $clog2(TICK_MAX) + 1;
    localparam int BLINK_W  = $clog2(BLINK_HALF) + 1;

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0]  DELAY_LAST = TCNT_W'(DELAY_TICKS - 1);
    localparam logic [TCNT_W-1:0]  CHIME_LAST = TCNT_W'(CHIME_TICKS - 1);
    localparam logic [TCNT_W-1:0]  TCNT_SAT   = TCNT_W'(TICK_MAX);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    state_t             state;
    state_t             nxt_state;
    logic [PRE_W-1:0]   pre_cnt;
    logic [PRE_W-1:0]   nxt_pre;
    logic [TCNT_W-1:0]  tick_cnt;
    logic [TCNT_W-1:0]  nxt_tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] nxt_blink;
    logic               w_reg;
    logic               c_reg;
    logic               nxt_w;
    logic               nxt_c;
    logic               tick;
    logic               viol;

    // Next-state, timer and chime-phase logic; key loss beats a cleared violation, which beats timer expiry.
    always_comb begin
        tick         = (pre_cnt == PRE_LAST);
        viol         = K & P & ~S;
        nxt_state    = state;
        nxt_pre      = tick ? '0 : pre_cnt + 1'b1;
        nxt_tick_cnt = (tick && (tick_cnt != TCNT_SAT)) ? tick_cnt + 1'b1 : tick_cnt;
        nxt_blink    = blink_cnt;
        nxt_c        = c_reg;
        nxt_w        = 1'b0;

        case (state)
            IDLE: begin
                if (K) begin
                    nxt_state = viol ? WAIT : SAFE;
                end
            end
            SAFE: begin
                if (!K) begin
                    nxt_state = IDLE;
                end else if (viol) begin
                    nxt_state = WAIT;
                end
            end
            WAIT: begin
                if (!K) begin
                    nxt_state = IDLE;
                end else if (!viol) begin
                    nxt_state = SAFE;
                end else if (tick && (tick_cnt == DELAY_LAST)) begin
                    nxt_state = CHIME;
                end
            end
            CHIME: begin
                if (!K) begin
                    nxt_state = IDLE;
                end else if (!viol) begin
                    nxt_state = SAFE;
                end else if (tick && (tick_cnt == CHIME_LAST)) begin
                    nxt_state = LIGHT;
                end
            end
            LIGHT: begin
                if (!K) begin
                    nxt_state = IDLE;
                end else if (!viol) begin
                    nxt_state = SAFE;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        if (nxt_state != state) begin
            nxt_pre      = '0;
            nxt_tick_cnt = '0;
            nxt_blink    = '0;
            nxt_c        = (nxt_state == CHIME);
        end else if (state == CHIME) begin
            if (tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    nxt_blink = '0;
                    nxt_c     = ~c_reg;
                end else begin
                    nxt_blink = blink_cnt + 1'b1;
                end
            end
        end else begin
            nxt_blink = '0;
            nxt_c     = 1'b0;
        end

        nxt_w = (nxt_state == CHIME) || (nxt_state == LIGHT);
    end

    // State, counter and output registers; reset silences everything immediately.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            w_reg     <= 1'b0;
            c_reg     <= 1'b0;
        end else begin
            state     <= nxt_state;
            pre_cnt   <= nxt_pre;
            tick_cnt  <= nxt_tick_cnt;
            blink_cnt <= nxt_blink;
            w_reg     <= nxt_w;
            c_reg     <= nxt_c;
        end
    end

    assign W     = w_reg;
    assign C     = c_reg;
    assign State = state;

endmodule
